// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: RGB -> gray -> |Gx|+|Gy| on R/G/B, valid/ready on both sides.
// Define SOBEL_THRESH_EN for a binary edge map against thresh_i.
//   state | meaning
//   IDLE  | waiting for an in_sof pixel; other pixels are accepted and dropped
//   RUN   | accepting frame pixels
//   FLUSH | input closed, dummy pixels drain the last line
//   DONE  | one-cycle frame-done pulse
module sobel_stream #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] cam_red_i,
  input  logic [PIX_W-1:0] cam_green_i,
  input  logic [PIX_W-1:0] cam_blue_i,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0] thresh_i,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic [PIX_W-1:0] sobel_red_o,
  output logic [PIX_W-1:0] sobel_green_o,
  output logic [PIX_W-1:0] sobel_blue_o,
  output logic             sobel_done_o,
  output logic             busy_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = $clog2(IMG_W + 2);
  localparam int GW = PIX_W + 8;
  localparam int SW = PIX_W + 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, ccol_q, ccol_d, wcol_q, wcol_d, cur_col;
  logic [RW-1:0]   row_q, row_d, crow_q, crow_d, wrow_q, wrow_d, cur_row;
  logic [PW-1:0]   prime_q, prime_d, fl_q, fl_d, cur_prime;
  logic            win_v_q, win_v_d;
  logic            out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_last_q, out_last_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] w_q [3][3];

  logic             adv, acc, start, dummy, feed, emit, border;
  logic [GW-1:0]    gsum;
  logic [PIX_W-1:0] gray, fdat, pix;
  logic signed [SW-1:0] e [3][3];
  logic signed [SW-1:0] gx, gy, ax, ay;
  logic [SW:0]      mag;

  always_comb begin
    gsum = GW'(77) * GW'(cam_red_i) + GW'(150) * GW'(cam_green_i) + GW'(29) * GW'(cam_blue_i);
    gray = PIX_W'(gsum >> 8);
  end

  // Magnitude of the window currently held in the window stage.
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e[i][j] = SW'(w_q[i][j]);
    gx = (e[0][2] + (e[1][2] <<< 1) + e[2][2]) - (e[0][0] + (e[1][0] <<< 1) + e[2][0]);
    gy = (e[2][0] + (e[2][1] <<< 1) + e[2][2]) - (e[0][0] + (e[0][1] <<< 1) + e[0][2]);
    ax = gx[SW-1] ? -gx : gx;
    ay = gy[SW-1] ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};
`ifdef SOBEL_THRESH_EN
    pix = (mag >= (SW+1)'(thresh_i)) ? '1 : '0;
`else
    pix = (mag > (SW+1)'((1 << PIX_W) - 1)) ? '1 : mag[PIX_W-1:0];
`endif
    border = (wrow_q == '0) || (wrow_q == RW'(IMG_H-1)) ||
             (wcol_q == '0) || (wcol_q == CW'(IMG_W-1));
    if (border) pix = '0;
  end

  always_comb begin
    adv       = !out_valid_q || out_ready;
    in_ready  = rst && adv && (state_q == IDLE || state_q == RUN);
    acc       = in_valid && in_ready;
    start     = acc && in_sof;
    dummy     = (state_q == FLUSH) && adv && (fl_q != PW'(IMG_W+1));
    feed      = (acc && (in_sof || state_q == RUN)) || dummy;
    fdat      = dummy ? '0 : gray;
    cur_col   = start ? '0 : col_q;
    cur_row   = start ? '0 : row_q;
    cur_prime = start ? '0 : prime_q;
    // A centre exists once a full line plus one pixel has been fed.
    emit      = feed && (cur_prime == PW'(IMG_W+1));

    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    prime_d     = prime_q;
    fl_d        = fl_q;
    ccol_d      = ccol_q;
    crow_d      = crow_q;
    win_v_d     = win_v_q;
    wcol_d      = wcol_q;
    wrow_d      = wrow_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_last_d  = out_last_q;
    out_pix_d   = out_pix_q;

    if (feed) begin
      col_d   = (cur_col == CW'(IMG_W-1)) ? '0 : cur_col + 1'b1;
      row_d   = cur_row;
      if (cur_col == CW'(IMG_W-1))
        row_d = (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + 1'b1;
      prime_d = emit ? cur_prime : cur_prime + 1'b1;
    end
    if (start) begin
      ccol_d = '0;
      crow_d = '0;
      fl_d   = '0;
    end
    if (emit) begin
      ccol_d = (ccol_q == CW'(IMG_W-1)) ? '0 : ccol_q + 1'b1;
      if (ccol_q == CW'(IMG_W-1))
        crow_d = (crow_q == RW'(IMG_H-1)) ? '0 : crow_q + 1'b1;
    end
    if (dummy) fl_d = fl_q + 1'b1;

    if (adv) begin
      win_v_d     = emit;
      wcol_d      = ccol_q;
      wrow_d      = crow_q;
      out_valid_d = win_v_q && !start;
      out_sof_d   = (wrow_q == '0) && (wcol_q == '0);
      out_last_d  = (wrow_q == RW'(IMG_H-1)) && (wcol_q == CW'(IMG_W-1));
      out_pix_d   = pix;
    end

    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (acc && !in_sof && col_q == CW'(IMG_W-1) && row_q == RW'(IMG_H-1))
               state_d = FLUSH;
      FLUSH: if (out_valid_q && out_ready && out_last_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      prime_q     <= '0;
      fl_q        <= '0;
      ccol_q      <= '0;
      crow_q      <= '0;
      win_v_q     <= 1'b0;
      wcol_q      <= '0;
      wrow_q      <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      prime_q     <= prime_d;
      fl_q        <= fl_d;
      ccol_q      <= ccol_d;
      crow_q      <= crow_d;
      win_v_q     <= win_v_d;
      wcol_q      <= wcol_d;
      wrow_q      <= wrow_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_last_q  <= out_last_d;
      out_pix_q   <= out_pix_d;
    end
  end

  // Line buffers and window hold data only; their contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (feed) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= fdat;
      for (int i = 0; i < 3; i++) begin
        w_q[i][0] <= w_q[i][1];
        w_q[i][1] <= w_q[i][2];
      end
      w_q[0][2] <= lb1[cur_col];
      w_q[1][2] <= lb0[cur_col];
      w_q[2][2] <= fdat;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_sof       = out_sof_q;
  assign sobel_red_o   = out_pix_q;
  assign sobel_green_o = out_pix_q;
  assign sobel_blue_o  = out_pix_q;
  assign sobel_done_o  = (state_q == DONE);
  assign busy_o        = (state_q == RUN) || (state_q == FLUSH);

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream at 8x6: step edges, stalls, frame abort, reset mid-frame.
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] cr = '0, cg = '0, cb = '0;
  logic       out_ready;
  logic       in_ready, out_valid, out_sof, sobel_done_o, busy_o;
  logic [7:0] sobel_red_o, sobel_green_o, sobel_blue_o;
`ifdef SOBEL_THRESH_EN
  logic [7:0] thresh = 8'd128;
`endif

  sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .cam_red_i(cr), .cam_green_i(cg), .cam_blue_i(cb),
`ifdef SOBEL_THRESH_EN
    .thresh_i(thresh),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .sobel_red_o(sobel_red_o), .sobel_green_o(sobel_green_o), .sobel_blue_o(sobel_blue_o),
    .sobel_done_o(sobel_done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] got[$];
  int done_cnt = 0, done_at = 0, stall_seen = 0, stab_viol = 0;
  int rdy_mode = 0;

  // out_ready: 0 = always 1, 1 = toggling 1,0,1,0..., 2 = held 0
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  logic        stall_prev = 1'b0;
  logic [24:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready)
        got.push_back({out_sof, sobel_red_o, sobel_green_o, sobel_blue_o});
      if (sobel_done_o) begin
        done_cnt = done_cnt + 1;
        done_at  = got.size();
      end
      if (stall_prev) begin
        stall_seen = stall_seen + 1;
        if (!out_valid || {out_sof, sobel_red_o, sobel_green_o, sobel_blue_o} != prev_out)
          stab_viol = stab_viol + 1;
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_sof, sobel_red_o, sobel_green_o, sobel_blue_o};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic sof);
    int n;
    n = 0;
    in_valid = 1'b1; in_sof = sof; cr = r; cg = g; cb = b;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    chk("in_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // kind 0: vertical step between cols 3|4; kind 1: horizontal step between rows 2|3
  function automatic logic [7:0] exp_pix(input int i, input int kind, input logic [7:0] ev);
    int r, c;
    r = i / W;
    c = i % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'd0;
    if (kind == 0 && (c == 3 || c == 4)) return ev;
    if (kind == 1 && (r == 2 || r == 3)) return ev;
    return 8'd0;
  endfunction

  task automatic send_pixels(input int kind, input int npix, input logic [7:0] lo,
                             input logic [7:0] hr, input logic [7:0] hg, input logic [7:0] hb,
                             input bit gaps);
    int n;
    bit hi;
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        n = $urandom_range(0, 2);
        repeat (n) begin @(posedge clk); #1; end
      end
      hi = (kind == 0) ? ((i % W) >= 4) : ((i / W) >= 3);
      if (hi) push(hr, hg, hb, i == 0);
      else    push(lo, lo, lo, i == 0);
    end
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 1000) begin @(negedge clk); n++; end
    chk("done_within_budget", {31'b0, done_cnt != d0}, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int base, input int d0,
                             input int kind, input logic [7:0] ev);
    logic [7:0] e;
    chk({tag, "_len"}, got.size() - base, 32'd48);
    for (int i = 0; i < 48; i++) begin
      if (base + i < got.size()) begin
        e = exp_pix(i, kind, ev);
        chk($sformatf("%s_pix%0d", tag, i), {7'b0, got[base+i]}, {7'b0, i == 0, e, e, e});
      end
    end
    chk({tag, "_done_count"}, done_cnt - d0, 32'd1);
    chk({tag, "_done_after_last"}, done_at, base + 48);
  endtask

  task automatic run_frame(input string tag, input int kind, input logic [7:0] lo,
                           input logic [7:0] hr, input logic [7:0] hg, input logic [7:0] hb,
                           input logic [7:0] ev, input bit gaps);
    int base, d0;
    base = got.size();
    d0 = done_cnt;
    send_pixels(kind, 48, lo, hr, hg, hb, gaps);
    wait_done(d0);
    check_frame(tag, base, d0, kind, ev);
  endtask

  initial begin
    int base, d0, base2, k, s0;
    logic [7:0] e;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_done", {31'b0, sobel_done_o}, 0);
    chk("rst_data", {7'b0, out_sof, sobel_red_o, sobel_green_o, sobel_blue_o}, 0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // pixels without in_sof in IDLE are dropped
    push(8'd200, 8'd200, 8'd200, 1'b0);
    push(8'd10, 8'd20, 8'd30, 1'b0);
    chk("idle_drop_busy", {31'b0, busy_o}, 0);
    chk("idle_drop_no_out", got.size(), 0);

    // test 1: uniform frame
    run_frame("uniform", 0, 8'd100, 8'd100, 8'd100, 8'd100, 8'd0, 1'b0);
    // test 2: vertical step 0 -> 40
    run_frame("vstep", 0, 8'd0, 8'd40, 8'd40, 8'd40, 8'd160, 1'b0);
    // gray weights: red only 100 -> 30, blue only 200 -> 22, green only 100 -> 58
    run_frame("red_step", 0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd120, 1'b0);
    run_frame("blue_step", 0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd88, 1'b0);
    run_frame("green_step", 0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd232, 1'b0);
    // saturation: 4*255 clips to 255; horizontal step exercises Gy
    run_frame("sat_step", 0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
    run_frame("hstep", 1, 8'd0, 8'd40, 8'd40, 8'd40, 8'd160, 1'b0);

    // test 3: backpressure and input gaps
    s0 = stall_seen;
    rdy_mode = 1;
    run_frame("stall", 0, 8'd0, 8'd40, 8'd40, 8'd40, 8'd160, 1'b1);
    rdy_mode = 0;
    chk("stall_observed", {31'b0, stall_seen > s0}, 32'd1);
    chk("stall_stability", stab_viol, 0);

    // test 4: in_sof again at input pixel 20
    base = got.size();
    d0 = done_cnt;
    send_pixels(0, 20, 8'd0, 8'd40, 8'd40, 8'd40, 1'b0);
    send_pixels(0, 48, 8'd0, 8'd40, 8'd40, 8'd40, 1'b0);
    wait_done(d0);
    base2 = base;
    for (int j = base + 1; j < got.size(); j++)
      if (got[j][24]) base2 = j;
    k = base2 - base;
    chk("abort_restart_found", {31'b0, k > 0}, 32'd1);
    chk("abort_prefix_bound", {31'b0, k <= 11}, 32'd1);
    for (int j = 0; j < k; j++) begin
      e = exp_pix(j, 0, 8'd160);
      chk($sformatf("abort_prefix%0d", j), {7'b0, got[base+j]}, {7'b0, j == 0, e, e, e});
    end
    check_frame("abort", base2, d0, 0, 8'd160);

    // test 5: reset pulse while RUN with a stalled output
    d0 = done_cnt;
    rdy_mode = 2;
    @(posedge clk); #1;
    send_pixels(0, 11, 8'd0, 8'd40, 8'd40, 8'd40, 1'b0);
    @(negedge clk);
    chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    chk("pre_rst_busy", {31'b0, busy_o}, 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("in_rst_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", {31'b0, out_valid}, 0);
    chk("post_rst_busy", {31'b0, busy_o}, 0);
    chk("post_rst_done", {31'b0, sobel_done_o}, 0);
    chk("post_rst_data", {7'b0, out_sof, sobel_red_o, sobel_green_o, sobel_blue_o}, 0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_no_done", done_cnt - d0, 0);
    run_frame("recover", 0, 8'd0, 8'd40, 8'd40, 8'd40, 8'd160, 1'b0);

`ifdef SOBEL_THRESH_EN
    // test 6: binary edge map at threshold 128
    thresh = 8'd128;
    run_frame("thr_step40", 0, 8'd0, 8'd40, 8'd40, 8'd40, 8'd255, 1'b0);
    run_frame("thr_step20", 0, 8'd0, 8'd20, 8'd20, 8'd20, 8'd0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
